// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add over one shared 4-bit slice; result valid NIB cycles after accept.
// Holds the result until out_ready and accepts nothing while busy; SERIAL_ADD_OVF_EN adds out_ovf.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while rst is asserted so nothing looks acceptable mid-reset.
                in_ready = !rst;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_cin = carry_q;
                carry_d = add_cout;
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        add_a            = a_q[4*i +: 4];
                        add_b            = b_q[4*i +: 4];
                        sum_d[4*i +: 4]  = add_sum;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = sum_q;
                out_cout  = carry_q;
                if (out_ready) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_ADD_OVF_EN
    assign out_ovf = (state_q == DONE) && (a_q[WIDTH-1] == b_q[WIDTH-1])
                     && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16 with a behavioural 4-bit slice.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_cin;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid, out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;
`ifdef SERIAL_ADD_OVF_EN
    logic        out_ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    logic cins [0:31];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
`ifdef SERIAL_ADD_OVF_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pair, let it be accepted, then scramble the inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = 1'b1;
    endtask

    // Count negedges from the accept until out_valid, logging the slice carry-in per step.
    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            cins[l] = add_cin;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic full_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic [15:0] es, input logic ec);
        start_op(a, b, c);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_cout"}, out_cout, ec);
    endtask

    initial begin
        logic [15:0] pa [0:2];
        logic [15:0] pb [0:2];
        logic        pc [0:2];
        logic [15:0] es [0:2];
        logic        ec [0:2];
        int          rcyc [0:2];
        int          pi, ri;
        logic        pend;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_add", {add_a, add_b, add_cin}, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", out_ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // 1: basic add with carry-in
        out_ready = 1'b1;
        full_add("t1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        @(negedge clk);
        chk("t1_vld_fall", out_valid, 0);
        chk("t1_in_ready", in_ready, 1);

        // 2: carry ripples through every nibble
        full_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        chk("t2_cin0", cins[0], 0);
        chk("t2_cin1", cins[1], 1);
        chk("t2_cin2", cins[2], 1);
        chk("t2_cin3", cins[3], 1);
        @(negedge clk);

        // 3: result held under backpressure, in_valid ignored in DONE
        out_ready = 1'b0;
        full_add("t3", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0);
        in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("t3_hold_vld", out_valid, 1);
            chk("t3_hold_sum", out_sum, 16'h1000);
            chk("t3_hold_cout", out_cout, 0);
            chk("t3_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_vld_fall", out_valid, 0);
        chk("t3_busy", busy, 0);
        chk("t3_in_ready_back", in_ready, 1);

        // 4: reset on the 2nd RUN cycle aborts the op
        start_op(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_vld", out_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_sum", out_sum, 0);
        chk("t4_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        full_add("t4b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        @(negedge clk);

        // 5: back-to-back with in_valid held high
        pa[0] = 16'h0F0F; pb[0] = 16'h0101; pc[0] = 1'b0; es[0] = 16'h1010; ec[0] = 1'b0;
        pa[1] = 16'h8000; pb[1] = 16'h8001; pc[1] = 1'b1; es[1] = 16'h0002; ec[1] = 1'b1;
        pa[2] = 16'hABCD; pb[2] = 16'h1111; pc[2] = 1'b0; es[2] = 16'hBCDE; ec[2] = 1'b0;
        pi = 0; ri = 0; pend = 1'b0;
        in_a = pa[0]; in_b = pb[0]; in_cin = pc[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid && ri < 3) begin
                chk("t5_sum", out_sum, es[ri]);
                chk("t5_cout", out_cout, ec[ri]);
                rcyc[ri] = cyc;
                ri++;
            end
            if (pend) begin
                pi++;
                if (pi < 3) begin
                    in_a = pa[pi]; in_b = pb[pi]; in_cin = pc[pi];
                end else begin
                    in_valid = 1'b0;
                end
            end
            pend = in_valid && in_ready;
            @(negedge clk);
        end
        chk("t5_count", ri, 3);
        if (ri == 3) begin
            chk("t5_gap01", rcyc[1] - rcyc[0], 6);
            chk("t5_gap12", rcyc[2] - rcyc[1], 6);
        end

`ifdef SERIAL_ADD_OVF_EN
        // 6: signed overflow flag
        full_add("t6a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        chk("t6a_ovf", out_ovf, 1);
        @(negedge clk);
        full_add("t6b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        chk("t6b_ovf", out_ovf, 1);
        @(negedge clk);
        full_add("t6c", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        chk("t6c_ovf", out_ovf, 0);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
